decode_queue: RTL and testbench
===============================

// Module: decode_queue
// PURPOSE
// - Parametrised decode stage between fetch and rename. Decodes up to WIDTH instruction words per bundle.
// - Honours a per-lane valid mask, buffers decoded bundles in a DEPTH-entry queue and supports pipeline flush.
// - Counts unsupported encodings.
// - Drop-in successor to the single-register decode stage; uses DecodeResult from processor_help.
// PARAMETERS
// - WIDTH    SUPER_SCALAR_WIDTH  lanes per bundle (1..8)
// - DEPTH    2                   decoded-bundle queue entries (power of two, >=2)
// - CNT_BITS 16                  width of unsupported-instruction counter
// PORTS
// - clk_in                 in   1               clock, all state on posedge
// - rst_in                 in   1               asynchronous, active-high reset
// - flush_in               in   1               discard all buffered and incoming bundles
// - fetch_ready_out        out  1               stage can accept a bundle this cycle
// - fetch_valid_in         in   1               fetch bundle valid
// - fetch_data_in          in   Word[WIDTH]     raw instruction words, lane 0 oldest
// - fetch_lane_valid_in    in   WIDTH           per-lane valid mask
// - rename_ready_in        in   1               rename accepts head bundle
// - rename_valid_out       out  1               head bundle valid
// - rename_payload_out     out  DecodeResult[WIDTH]  decoded head bundle
// - rename_lane_valid_out  out  WIDTH           per-lane valid of head bundle
// - occupancy_out          out  $clog2(DEPTH)+1 bundles currently queued
// - unsupported_count_out  out  CNT_BITS        saturating count of valid lanes decoded UNSUPPORTED
// BEHAVIOUR
// - Reset (async):
//   - pointers, occupancy and counter clear to 0; rename_valid_out=0; rename_lane_valid_out=0.
//   - Payload storage is cleared to all-zero.
// - Handshakes:
//   - fetch_hs = fetch_valid_in && fetch_ready_out.
//   - rename_hs = rename_valid_out && rename_ready_in.
// - fetch_ready_out = !flush_in && (occupancy<DEPTH || rename_ready_in). Combinational; full+pop accepts same cycle.
// - rename_valid_out = (occupancy!=0), driven from registered state. Payload is the head entry.
// - Latency: bundle accepted in cycle N is visible at rename in cycle N+1 when the queue was empty.
//   FIFO order is strictly preserved.
// - Simultaneous push and pop: occupancy unchanged; no bubble.
// - A bundle whose fetch_lane_valid_in is all-zero completes the handshake but is not enqueued.
// - Invalid lanes in an enqueued bundle:
//   - payload forced to all-zero, lane_valid=0;
//   - not counted as unsupported.
// - flush_in=1 (highest priority, synchronous):
//   - queue emptied at the next edge;
//   - same-cycle fetch data dropped;
//   - rename_valid_out=0 the following cycle;
//   - counter unaffected.
// - Reset mid-operation: all queued bundles lost, outputs return to reset values immediately.
// - Pointers wrap modulo DEPTH. Occupancy never exceeds DEPTH.
// - Per-lane decode (opcode = w[3:0]):
//   - Fields not written by an opcode are 0. This replaces the previous hold-last-value behaviour.
//   - Immediates are sign-extended to WORD_WIDTH.
//   - LUI:  rd=w[9:4], imm={w[24:10],10'b0}
//   - JAL:  rd=w[9:4], imm=sext(w[24:10])
//   - JALR/LOAD: rd=w[9:4], rs1=w[15:10], imm=sext(w[24:16])
//   - STORE: rs1=w[9:4], rs2=w[15:10], imm=sext(w[24:16])
//   - BRANCH: rs1=w[12:7], rs2=w[18:13], imm=sext(w[24:19])
//     - funct=w[6:4] selects EQ/NEQ/LT/GE/LTU/GEU; else UNSUPPORTED.
//   - OP_IMM_NORMAL/OP_NORMAL: rd=w[12:7], rs1=w[18:13]
//     - imm=sext(w[24:19]) or rs2=w[24:19]
//     - funct 0..5 -> alu_operation ADD,SLT,SLTU,XOR,OR,AND; else UNSUPPORTED.
//   - OP_IMM_SHIFT/OP_SHIFT: same fields; funct 0..2 -> SLL,SRL,SRA; else UNSUPPORTED.
//   - Any other opcode: UNSUPPORTED.
// - Counter:
//   - adds the popcount of valid UNSUPPORTED lanes on each enqueue;
//   - saturates at 2^CNT_BITS-1;
//   - cleared only by reset.
// STRUCTURE
// - processor_help holds:
//   - Word, WORD_WIDTH, opcode/ALU/branch enums, DecodeResult;
//   - new constant DECODE_QUEUE_DEPTH=2.
// - Sub-module decode_lane: purely combinational Word -> DecodeResult + unsupported flag.
//   - Instantiated WIDTH times via generate.
// - Top level: queue storage, pointers, occupancy, flush, counter.
// TESTING
// - Reset: rst_in pulsed mid-stream -> rename_valid_out=0, occupancy_out=0 and count=0 in the same cycle.
// - Streaming: WIDTH=2, rename_ready_in=1, LUI rd=5 w[24:10]=1 each cycle.
//   - Expect rename_valid_out from cycle 1, immediate=0x400, rd=5.
//   - Expect one bundle per cycle with no bubble.
// - Backpressure: rename_ready_in=0, push 3 bundles, DEPTH=2.
//   - fetch_ready_out drops after 2 accepted.
//   - Raising ready with valid high gives push+pop in the same cycle; output order is A,B,C.
// - Lane mask: mask=2'b01, lane1 opcode invalid.
//   - lane_valid=01, lane1 payload=0, count stays 0.
//   - mask=2'b00 bundle is never enqueued.
// - Decode corners: OP_NORMAL funct=5 -> alu_operation=AND.
//   - BRANCH funct=7 -> UNSUPPORTED, count+1.
//   - JALR w[24:16]=9'h1FF -> imm=-1.
// - Flush: queue holds 2 bundles; flush_in with fetch_valid_in=1 -> fetch_ready_out=0, next cycle occupancy=0 and valid=0.
//   - Count is preserved.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// ---------------------------------------------------------------------------
// decode_queue_pkg
// Helpers local to the decode queue: the widest bundle the queue supports
// and a population count used to total unsupported lanes per bundle.
// ---------------------------------------------------------------------------
package decode_queue_pkg;

  localparam int DQ_MAX_WIDTH = 8;

  // Number of set bits in an 8-bit lane mask (narrower masks are
  // zero-extended by the caller).
  function automatic logic [3:0] popcount8(input logic [DQ_MAX_WIDTH-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < DQ_MAX_WIDTH; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/processor_help.sv
// ---------------------------------------------------------------------------
// processor_help
// Shared processor-wide types: the instruction word, the opcode / ALU /
// branch enumerations and the DecodeResult record handed from decode to
// rename. Also holds the default superscalar width and the default depth of
// the decoded-bundle queue.
// ---------------------------------------------------------------------------
package processor_help;

  localparam int WORD_WIDTH         = 32;
  localparam int REG_BITS           = 6;
  localparam int SUPER_SCALAR_WIDTH = 2;
  localparam int DECODE_QUEUE_DEPTH = 2;

  typedef logic [WORD_WIDTH-1:0] Word;
  typedef logic [REG_BITS-1:0]   RegIdx;

  // Major opcode, held in w[3:0]. Values 10..15 are unassigned.
  typedef enum logic [3:0] {
    OPC_LUI           = 4'd0,
    OPC_JAL           = 4'd1,
    OPC_JALR          = 4'd2,
    OPC_BRANCH        = 4'd3,
    OPC_LOAD          = 4'd4,
    OPC_STORE         = 4'd5,
    OPC_OP_IMM_NORMAL = 4'd6,
    OPC_OP_IMM_SHIFT  = 4'd7,
    OPC_OP_NORMAL     = 4'd8,
    OPC_OP_SHIFT      = 4'd9
  } Opcode;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SLT  = 4'd1,
    ALU_SLTU = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_AND  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8
  } AluOp;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NEQ = 3'd1,
    BR_LT  = 3'd2,
    BR_GE  = 3'd3,
    BR_LTU = 3'd4,
    BR_GEU = 3'd5
  } BranchOp;

  // Decoded instruction. Fields an opcode does not use are zero; an
  // unsupported encoding is all-zero apart from the unsupported flag.
  typedef struct packed {
    logic    unsupported;
    Opcode   opcode;
    RegIdx   rd;
    RegIdx   rs1;
    RegIdx   rs2;
    Word     imm;
    AluOp    alu_operation;
    BranchOp branch_operation;
  } DecodeResult;

endpackage

// File: rtl/decode_lane.sv
// ---------------------------------------------------------------------------
// decode_lane
// Purely combinational decoder for one instruction word.
// Ports:
//   word_in         raw instruction word (opcode in w[3:0])
//   result_out      decoded fields; unused fields are zero
//   unsupported_out high when the encoding is not recognised
// ---------------------------------------------------------------------------
module decode_lane
  import processor_help::*;
(
  input  Word         word_in,
  output DecodeResult result_out,
  output logic        unsupported_out
);

  logic [2:0] funct;
  logic       bad;
  Word        imm_u;
  Word        imm_j;
  Word        imm_i;
  Word        imm_s;
  DecodeResult result;

  // Bits above the widest immediate are not part of any encoding.
  logic unused_upper;
  assign unused_upper = ^word_in[WORD_WIDTH-1:25];

  assign funct = word_in[6:4];

  // All immediate formats sign-extend from w[24].
  assign imm_u = {{(WORD_WIDTH-25){word_in[24]}}, word_in[24:10], 10'b0};
  assign imm_j = {{(WORD_WIDTH-15){word_in[24]}}, word_in[24:10]};
  assign imm_i = {{(WORD_WIDTH-9){word_in[24]}},  word_in[24:16]};
  assign imm_s = {{(WORD_WIDTH-6){word_in[24]}},  word_in[24:19]};

  // Field extraction per opcode. A bad funct on an otherwise known opcode
  // is treated exactly like an unknown opcode, so the record is zeroed at
  // the end rather than keeping half-decoded fields.
  always_comb begin
    result = '0;
    bad    = 1'b0;
    case (word_in[3:0])
      OPC_LUI: begin
        result.opcode = OPC_LUI;
        result.rd     = word_in[9:4];
        result.imm    = imm_u;
      end
      OPC_JAL: begin
        result.opcode = OPC_JAL;
        result.rd     = word_in[9:4];
        result.imm    = imm_j;
      end
      OPC_JALR, OPC_LOAD: begin
        result.opcode = Opcode'(word_in[3:0]);
        result.rd     = word_in[9:4];
        result.rs1    = word_in[15:10];
        result.imm    = imm_i;
      end
      OPC_STORE: begin
        result.opcode = OPC_STORE;
        result.rs1    = word_in[9:4];
        result.rs2    = word_in[15:10];
        result.imm    = imm_i;
      end
      OPC_BRANCH: begin
        if (funct <= 3'd5) begin
          result.opcode           = OPC_BRANCH;
          result.rs1              = word_in[12:7];
          result.rs2              = word_in[18:13];
          result.imm              = imm_s;
          result.branch_operation = BranchOp'(funct);
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OP_IMM_NORMAL, OPC_OP_NORMAL: begin
        if (funct <= 3'd5) begin
          result.opcode        = Opcode'(word_in[3:0]);
          result.rd            = word_in[12:7];
          result.rs1           = word_in[18:13];
          result.alu_operation = AluOp'({1'b0, funct});
          if (word_in[3:0] == OPC_OP_IMM_NORMAL) begin
            result.imm = imm_s;
          end else begin
            result.rs2 = word_in[24:19];
          end
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OP_IMM_SHIFT, OPC_OP_SHIFT: begin
        if (funct <= 3'd2) begin
          result.opcode = Opcode'(word_in[3:0]);
          result.rd     = word_in[12:7];
          result.rs1    = word_in[18:13];
          case (funct)
            3'd0:    result.alu_operation = ALU_SLL;
            3'd1:    result.alu_operation = ALU_SRL;
            default: result.alu_operation = ALU_SRA;
          endcase
          if (word_in[3:0] == OPC_OP_IMM_SHIFT) begin
            result.imm = imm_s;
          end else begin
            result.rs2 = word_in[24:19];
          end
        end else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      result             = '0;
      result.unsupported = 1'b1;
    end
  end

  assign result_out      = result;
  assign unsupported_out = bad;

endmodule

// File: rtl/decode_queue.sv
// ---------------------------------------------------------------------------
// decode_queue
// Decode stage between fetch and rename. Decodes up to WIDTH words per
// bundle, buffers decoded bundles in a DEPTH-entry FIFO and counts valid
// lanes carrying unsupported encodings.
// Ports:
//   clk_in, rst_in            clock; asynchronous active-high reset
//   flush_in                  drop everything queued and the incoming bundle
//   fetch_ready_out           bundle can be accepted this cycle
//   fetch_valid_in            fetch bundle valid
//   fetch_data_in             raw words, lane 0 oldest
//   fetch_lane_valid_in       per-lane valid mask
//   rename_ready_in           rename takes the head bundle
//   rename_valid_out          head bundle valid
//   rename_payload_out        decoded head bundle
//   rename_lane_valid_out     per-lane valid of head bundle
//   occupancy_out             bundles currently queued
//   unsupported_count_out     saturating count of unsupported valid lanes
// ---------------------------------------------------------------------------
module decode_queue
  import processor_help::*, decode_queue_pkg::*;
#(
  parameter int WIDTH    = SUPER_SCALAR_WIDTH,
  parameter int DEPTH    = DECODE_QUEUE_DEPTH,
  parameter int CNT_BITS = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        flush_in,
  output logic                        fetch_ready_out,
  input  logic                        fetch_valid_in,
  input  Word         [WIDTH-1:0]     fetch_data_in,
  input  logic        [WIDTH-1:0]     fetch_lane_valid_in,
  input  logic                        rename_ready_in,
  output logic                        rename_valid_out,
  output DecodeResult [WIDTH-1:0]     rename_payload_out,
  output logic        [WIDTH-1:0]     rename_lane_valid_out,
  output logic [$clog2(DEPTH):0]      occupancy_out,
  output logic [CNT_BITS-1:0]         unsupported_count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int SUM_W = CNT_BITS + 1;

  DecodeResult [WIDTH-1:0] decoded;
  DecodeResult [WIDTH-1:0] masked_bundle;
  logic        [WIDTH-1:0] lane_unsupported;

  DecodeResult [WIDTH-1:0] payload_q    [DEPTH];
  DecodeResult [WIDTH-1:0] payload_d    [DEPTH];
  logic        [WIDTH-1:0] lane_valid_q [DEPTH];
  logic        [WIDTH-1:0] lane_valid_d [DEPTH];
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic [CNT_BITS-1:0]     count_q, count_d;

  logic             fetch_hs;
  logic             rename_hs;
  logic             push;
  logic             pop;
  logic [3:0]       bad_lanes;
  logic [SUM_W-1:0] count_sum;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    decode_lane u_decode_lane (
      .word_in         (fetch_data_in[g]),
      .result_out      (decoded[g]),
      .unsupported_out (lane_unsupported[g])
    );
  end

  // Invalid lanes are stored as zero so rename never sees stale fields.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      masked_bundle[i] = fetch_lane_valid_in[i] ? decoded[i] : '0;
    end
  end

  // A full queue still accepts when the head leaves in the same cycle.
  assign fetch_ready_out  = !flush_in && ((occ_q < OCC_W'(DEPTH)) || rename_ready_in);
  assign rename_valid_out = (occ_q != '0);
  assign fetch_hs         = fetch_valid_in && fetch_ready_out;
  assign rename_hs        = rename_valid_out && rename_ready_in;
  // An all-invalid bundle handshakes but occupies no slot.
  assign push             = fetch_hs && (|fetch_lane_valid_in);
  assign pop              = rename_hs;

  assign bad_lanes = popcount8(DQ_MAX_WIDTH'(fetch_lane_valid_in & lane_unsupported));
  assign count_sum = {1'b0, count_q} + SUM_W'(bad_lanes);

  // Next-state for pointers, occupancy, storage and the counter. Flush
  // wins over everything except reset and leaves the counter alone.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    occ_d        = occ_q;
    payload_d    = payload_q;
    lane_valid_d = lane_valid_q;
    count_d      = count_q;
    if (flush_in) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (push) begin
        payload_d[tail_q]    = masked_bundle;
        lane_valid_d[tail_q] = fetch_lane_valid_in;
        tail_d               = tail_q + PTR_W'(1);
        count_d              = count_sum[CNT_BITS] ? '1 : count_sum[CNT_BITS-1:0];
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // State registers, including the payload storage, all clear on reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        payload_q[i]    <= '0;
        lane_valid_q[i] <= '0;
      end
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      occ_q        <= occ_d;
      count_q      <= count_d;
      payload_q    <= payload_d;
      lane_valid_q <= lane_valid_d;
    end
  end

  // Head outputs read as zero whenever the queue is empty.
  assign rename_payload_out    = rename_valid_out ? payload_q[head_q]    : '0;
  assign rename_lane_valid_out = rename_valid_out ? lane_valid_q[head_q] : '0;
  assign occupancy_out         = occ_q;
  assign unsupported_count_out = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_decode_queue
// Self-checking bench for decode_queue (WIDTH=2, DEPTH=2). A queue-based
// model tracks what rename should see; a negedge process compares the DUT
// against it every cycle, and directed steps add hand-computed checks.
// ---------------------------------------------------------------------------
module tb_decode_queue;
  import processor_help::*;

  localparam int W  = 2;
  localparam int D  = 2;
  localparam int CB = 16;

  logic                    clk_in;
  logic                    rst_in;
  logic                    flush_in;
  logic                    fetch_ready_out;
  logic                    fetch_valid_in;
  Word         [W-1:0]     fetch_data_in;
  logic        [W-1:0]     fetch_lane_valid_in;
  logic                    rename_ready_in;
  logic                    rename_valid_out;
  DecodeResult [W-1:0]     rename_payload_out;
  logic        [W-1:0]     rename_lane_valid_out;
  logic [$clog2(D):0]      occupancy_out;
  logic [CB-1:0]           unsupported_count_out;

  int total = 0;
  int bad   = 0;

  decode_queue #(.WIDTH(W), .DEPTH(D), .CNT_BITS(CB)) dut (
    .clk_in                (clk_in),
    .rst_in                (rst_in),
    .flush_in              (flush_in),
    .fetch_ready_out       (fetch_ready_out),
    .fetch_valid_in        (fetch_valid_in),
    .fetch_data_in         (fetch_data_in),
    .fetch_lane_valid_in   (fetch_lane_valid_in),
    .rename_ready_in       (rename_ready_in),
    .rename_valid_out      (rename_valid_out),
    .rename_payload_out    (rename_payload_out),
    .rename_lane_valid_out (rename_lane_valid_out),
    .occupancy_out         (occupancy_out),
    .unsupported_count_out (unsupported_count_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Instruction encoders
  function automatic Word enc_lui(input logic [5:0] rd, input logic [14:0] hi);
    Word w;
    w = '0;
    w[3:0] = OPC_LUI;
    w[9:4] = rd;
    w[24:10] = hi;
    return w;
  endfunction

  function automatic Word enc_ld(input logic [3:0] opc, input logic [5:0] rd, input logic [5:0] rs1, input logic [8:0] imm9);
    Word w;
    w = '0;
    w[3:0] = opc;
    w[9:4] = rd;
    w[15:10] = rs1;
    w[24:16] = imm9;
    return w;
  endfunction

  function automatic Word enc_alu(input logic [3:0] opc, input logic [2:0] fn, input logic [5:0] rd, input logic [5:0] rs1, input logic [5:0] f6);
    Word w;
    w = '0;
    w[3:0] = opc;
    w[6:4] = fn;
    w[12:7] = rd;
    w[18:13] = rs1;
    w[24:19] = f6;
    return w;
  endfunction

  function automatic Word enc_branch(input logic [2:0] fn, input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] imm6);
    Word w;
    w = '0;
    w[3:0] = OPC_BRANCH;
    w[6:4] = fn;
    w[12:7] = rs1;
    w[18:13] = rs2;
    w[24:19] = imm6;
    return w;
  endfunction

  // Reference decoder: sign extension via arithmetic shifts, ALU choice
  // via lookup tables.
  function automatic DecodeResult model_decode(input Word w);
    DecodeResult r;
    int op;
    int fn;
    AluOp normal_tab [6];
    AluOp shift_tab [3];
    normal_tab = '{ALU_ADD, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND};
    shift_tab  = '{ALU_SLL, ALU_SRL, ALU_SRA};
    op = int'(w[3:0]);
    fn = int'(w[6:4]);
    r = '0;
    if (op == int'(OPC_LUI)) begin
      r.opcode = OPC_LUI; r.rd = w[9:4];
      r.imm = Word'($signed({w[24:10], 17'b0}) >>> 7);
    end else if (op == int'(OPC_JAL)) begin
      r.opcode = OPC_JAL; r.rd = w[9:4];
      r.imm = Word'($signed({w[24:10], 17'b0}) >>> 17);
    end else if (op == int'(OPC_JALR) || op == int'(OPC_LOAD)) begin
      r.opcode = (op == int'(OPC_JALR)) ? OPC_JALR : OPC_LOAD;
      r.rd = w[9:4]; r.rs1 = w[15:10];
      r.imm = Word'($signed({w[24:16], 23'b0}) >>> 23);
    end else if (op == int'(OPC_STORE)) begin
      r.opcode = OPC_STORE; r.rs1 = w[9:4]; r.rs2 = w[15:10];
      r.imm = Word'($signed({w[24:16], 23'b0}) >>> 23);
    end else if (op == int'(OPC_BRANCH) && fn < 6) begin
      r.opcode = OPC_BRANCH; r.rs1 = w[12:7]; r.rs2 = w[18:13];
      r.imm = Word'($signed({w[24:19], 26'b0}) >>> 26);
      r.branch_operation = BranchOp'(fn);
    end else if ((op == int'(OPC_OP_IMM_NORMAL) && fn < 6) || (op == int'(OPC_OP_IMM_SHIFT) && fn < 3)) begin
      r.opcode = (op == int'(OPC_OP_IMM_NORMAL)) ? OPC_OP_IMM_NORMAL : OPC_OP_IMM_SHIFT;
      r.rd = w[12:7]; r.rs1 = w[18:13];
      r.imm = Word'($signed({w[24:19], 26'b0}) >>> 26);
      r.alu_operation = (op == int'(OPC_OP_IMM_NORMAL)) ? normal_tab[fn] : shift_tab[fn];
    end else if ((op == int'(OPC_OP_NORMAL) && fn < 6) || (op == int'(OPC_OP_SHIFT) && fn < 3)) begin
      r.opcode = (op == int'(OPC_OP_NORMAL)) ? OPC_OP_NORMAL : OPC_OP_SHIFT;
      r.rd = w[12:7]; r.rs1 = w[18:13]; r.rs2 = w[24:19];
      r.alu_operation = (op == int'(OPC_OP_NORMAL)) ? normal_tab[fn] : shift_tab[fn];
    end else begin
      r.unsupported = 1'b1;
    end
    return r;
  endfunction

  // Model state: a queue of expected bundles and the expected counter.
  typedef struct {
    logic        [W-1:0] lv;
    DecodeResult [W-1:0] pl;
  } bundle_t;

  bundle_t mq [$];
  int      mcnt = 0;
  bit      m_ready;
  bit      m_pop;
  bit      m_push;
  bundle_t m_b;
  DecodeResult m_r;

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mq.delete();
      mcnt = 0;
    end else if (flush_in) begin
      mq.delete();
    end else begin
      m_ready = (mq.size() < D) || rename_ready_in;
      m_pop   = (mq.size() != 0) && rename_ready_in;
      m_push  = fetch_valid_in && m_ready && (fetch_lane_valid_in != '0);
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        m_b.lv = fetch_lane_valid_in;
        for (int i = 0; i < W; i++) begin
          m_r = model_decode(fetch_data_in[i]);
          m_b.pl[i] = fetch_lane_valid_in[i] ? m_r : '0;
          if (fetch_lane_valid_in[i] && m_r.unsupported) mcnt++;
        end
        if (mcnt > (2**CB) - 1) mcnt = (2**CB) - 1;
        mq.push_back(m_b);
      end
    end
  end

  bit exp_valid;
  always @(negedge clk_in) begin
    exp_valid = (mq.size() != 0);
    checkOutput("cyc_ready", fetch_ready_out, !flush_in && ((mq.size() < D) || rename_ready_in));
    checkOutput("cyc_valid", rename_valid_out, exp_valid);
    checkOutput("cyc_occupancy", occupancy_out, mq.size());
    checkOutput("cyc_count", unsupported_count_out, mcnt);
    if (exp_valid) begin
      checkOutput("cyc_lane_valid", rename_lane_valid_out, mq[0].lv);
      checkOutput("cyc_payload", rename_payload_out, mq[0].pl);
    end
  end

  task automatic applyStimulus(input logic v, input Word w0, input Word w1, input logic [W-1:0] mask,
                               input logic rready, input logic flush);
    fetch_valid_in      = v;
    fetch_data_in[0]    = w0;
    fetch_data_in[1]    = w1;
    fetch_lane_valid_in = mask;
    rename_ready_in     = rready;
    flush_in            = flush;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_in = 1'b1;
    applyStimulus(1'b0, '0, '0, 2'b00, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_valid", rename_valid_out, 1'b0);
    checkOutput("reset_occ", occupancy_out, 0);
    checkOutput("reset_count", unsupported_count_out, 0);
    checkOutput("reset_lane_valid", rename_lane_valid_out, 2'b00);
    rst_in = 1'b0;
    tick();

    // Streaming: one bundle per cycle, no bubble
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, enc_lui(6'd5, 15'd1), enc_lui(6'(10 + i), 15'd1), 2'b11, 1'b1, 1'b0);
      tick();
      checkOutput("stream_valid", rename_valid_out, 1'b1);
      checkOutput("stream_imm", rename_payload_out[0].imm, 32'h400);
      checkOutput("stream_rd", rename_payload_out[0].rd, 5);
      checkOutput("stream_order", rename_payload_out[1].rd, 10 + i);
      checkOutput("stream_occ", occupancy_out, 1);
    end
    applyStimulus(1'b0, '0, '0, 2'b00, 1'b1, 1'b0);
    tick();

    // Backpressure: A, B fill the queue; C waits, then push+pop
    applyStimulus(1'b1, enc_lui(6'd1, 15'd0), enc_lui(6'd1, 15'd0), 2'b11, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, enc_lui(6'd2, 15'd0), enc_lui(6'd2, 15'd0), 2'b11, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, enc_lui(6'd3, 15'd0), enc_lui(6'd3, 15'd0), 2'b11, 1'b0, 1'b0);
    checkOutput("bp_full_ready", fetch_ready_out, 1'b0);
    checkOutput("bp_full_occ", occupancy_out, 2);
    checkOutput("bp_head_a", rename_payload_out[0].rd, 1);
    tick();
    applyStimulus(1'b1, enc_lui(6'd3, 15'd0), enc_lui(6'd3, 15'd0), 2'b11, 1'b1, 1'b0);
    checkOutput("bp_pushpop_ready", fetch_ready_out, 1'b1);
    tick();
    checkOutput("bp_head_b", rename_payload_out[0].rd, 2);
    checkOutput("bp_occ_kept", occupancy_out, 2);
    applyStimulus(1'b0, '0, '0, 2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("bp_head_c", rename_payload_out[0].rd, 3);
    tick();

    // Lane mask
    applyStimulus(1'b1, enc_lui(6'd7, 15'd3), 32'h0000_000F, 2'b01, 1'b1, 1'b0);
    tick();
    checkOutput("mask_lane_valid", rename_lane_valid_out, 2'b01);
    checkOutput("mask_lane1_zero", rename_payload_out[1], '0);
    checkOutput("mask_count", unsupported_count_out, 0);
    applyStimulus(1'b1, enc_lui(6'd8, 15'd0), enc_lui(6'd9, 15'd0), 2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("mask_empty_occ", occupancy_out, 0);
    checkOutput("mask_empty_valid", rename_valid_out, 1'b0);

    // Decode corners
    applyStimulus(1'b1, enc_alu(OPC_OP_NORMAL, 3'd5, 6'd3, 6'd4, 6'd5), enc_branch(3'd7, 6'd1, 6'd2, 6'd0),
                  2'b11, 1'b1, 1'b0);
    tick();
    checkOutput("dec_and", rename_payload_out[0].alu_operation, ALU_AND);
    checkOutput("dec_and_rs2", rename_payload_out[0].rs2, 5);
    checkOutput("dec_branch_unsup", rename_payload_out[1].unsupported, 1'b1);
    checkOutput("dec_count", unsupported_count_out, 1);
    applyStimulus(1'b1, enc_ld(OPC_JALR, 6'd1, 6'd2, 9'h1FF), enc_lui(6'd1, 15'd0), 2'b11, 1'b1, 1'b0);
    tick();
    checkOutput("dec_jalr_imm", rename_payload_out[0].imm, 32'hFFFF_FFFF);
    checkOutput("dec_jalr_rs1", rename_payload_out[0].rs1, 2);
    applyStimulus(1'b0, '0, '0, 2'b00, 1'b1, 1'b0);
    tick();

    // Flush with two bundles queued
    applyStimulus(1'b1, enc_lui(6'd20, 15'd0), enc_lui(6'd21, 15'd0), 2'b11, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("flush_pre_occ", occupancy_out, 2);
    applyStimulus(1'b1, enc_lui(6'd22, 15'd0), enc_lui(6'd23, 15'd0), 2'b11, 1'b0, 1'b1);
    checkOutput("flush_ready", fetch_ready_out, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 2'b00, 1'b0, 1'b0);
    checkOutput("flush_occ", occupancy_out, 0);
    checkOutput("flush_valid", rename_valid_out, 1'b0);
    checkOutput("flush_count", unsupported_count_out, 1);

    // Reset mid-stream
    applyStimulus(1'b1, enc_lui(6'd24, 15'd0), enc_lui(6'd25, 15'd0), 2'b11, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 2'b00, 1'b0, 1'b0);
    checkOutput("mid_pre_occ", occupancy_out, 1);
    rst_in = 1'b1;
    #1;
    checkOutput("mid_reset_valid", rename_valid_out, 1'b0);
    checkOutput("mid_reset_occ", occupancy_out, 0);
    checkOutput("mid_reset_count", unsupported_count_out, 0);
    checkOutput("mid_reset_lane_valid", rename_lane_valid_out, 2'b00);
    tick();
    rst_in = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
